// File: rtl/mini_src_pkg.sv
// Mini SRC control unit shared definitions: opcodes, IR field positions,
// FSM state encoding, step numbering and instruction classification.
// Optional feature macro: MINI_SRC_MULDIV_EN (decodes mul/div/mfhi/mflo).
package mini_src_pkg;

    localparam int STEP_W = 4;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b10100;
    localparam logic [4:0] OP_MFLO = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [STEP_W-1:0] T0 = 4'd0;
    localparam logic [STEP_W-1:0] T3 = 4'd3;
    localparam logic [STEP_W-1:0] T4 = 4'd4;
    localparam logic [STEP_W-1:0] T5 = 4'd5;
    localparam logic [STEP_W-1:0] T6 = 4'd6;
    localparam logic [STEP_W-1:0] T7 = 4'd7;
    localparam logic [STEP_W-1:0] T8 = 4'd8;
    localparam logic [STEP_W-1:0] T9 = 4'd9;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_IMM, C_UNARY, C_LD, C_ST, C_NOP, C_HALT,
        C_MULDIV, C_MFHI, C_MFLO, C_ILLEGAL
    } iclass_t;

    typedef enum logic [3:0] {
        A_NONE, A_ADD, A_SUB, A_MUL, A_DIV, A_SHR, A_SHRA, A_SHL,
        A_ROR, A_ROL, A_AND, A_OR, A_NEG, A_NOT
    } alu_t;

    // Instruction class decides the execute sequence shape.
    function automatic iclass_t classify(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:         return C_RALU;
            OP_ADDI, OP_ANDI, OP_ORI:              return C_IMM;
            OP_NEG, OP_NOT:                        return C_UNARY;
            OP_LD:                                 return C_LD;
            OP_ST:                                 return C_ST;
            OP_NOP:                                return C_NOP;
            OP_HALT:                               return C_HALT;
`ifdef MINI_SRC_MULDIV_EN
            OP_MUL, OP_DIV:                        return C_MULDIV;
            OP_MFHI:                               return C_MFHI;
            OP_MFLO:                               return C_MFLO;
`endif
            default:                               return C_ILLEGAL;
        endcase
    endfunction

    // ALU operation issued by an opcode; memory ops compute address with ADD.
    function automatic alu_t alu_of(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_ST: return A_ADD;
            OP_SUB:                        return A_SUB;
            OP_MUL:                        return A_MUL;
            OP_DIV:                        return A_DIV;
            OP_SHR:                        return A_SHR;
            OP_SHRA:                       return A_SHRA;
            OP_SHL:                        return A_SHL;
            OP_ROR:                        return A_ROR;
            OP_ROL:                        return A_ROL;
            OP_AND, OP_ANDI:               return A_AND;
            OP_OR, OP_ORI:                 return A_OR;
            OP_NEG:                        return A_NEG;
            OP_NOT:                        return A_NOT;
            default:                       return A_NONE;
        endcase
    endfunction

    // Final execute step of each class; Stop is honoured only there.
    function automatic logic [STEP_W-1:0] last_step(input iclass_t c);
        case (c)
            C_RALU, C_IMM: return T6;
            C_UNARY:       return T5;
            C_LD:          return T9;
            C_ST:          return T8;
            C_MULDIV:      return T7;
            default:       return T4;
        endcase
    endfunction

endpackage

// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the Mini SRC control unit (master) and the
// datapath (slave): IR and Stop in, Run/Illegal and every strobe out.
interface mini_src_control_unit_if;
    logic [31:0] IR;
    logic        Stop;
    logic        Run;
    logic        Illegal;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout;
    logic PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin;
    logic IncPC, Read, RAMRead, RAMWrite;
    logic ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT;

    modport master (
        input  IR, Stop,
        output Run, Illegal, Rin, Rout,
        output PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout,
        output PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin,
        output IncPC, Read, RAMRead, RAMWrite,
        output ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT
    );

    modport slave (
        output IR, Stop,
        input  Run, Illegal, Rin, Rout,
        input  PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout,
        input  PCin, IRin, Yin, Zin, MARin, MDRin, LOin, HIin,
        input  IncPC, Read, RAMRead, RAMWrite,
        input  ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, AND, OR, NEG, NOT
    );
endinterface

// File: rtl/mini_src_reg_select.sv
// Register select: picks ra/rb/rc by Gra/Grb/Grc and produces one-hot
// register load and bus-drive vectors. R0 is never loaded.
module mini_src_reg_select (
    input  logic [3:0]  i_ra,
    input  logic [3:0]  i_rb,
    input  logic [3:0]  i_rc,
    input  logic        i_gra,
    input  logic        i_grb,
    input  logic        i_grc,
    input  logic        i_rin_en,
    input  logic        i_rout_en,
    output logic [15:0] o_rin,
    output logic [15:0] o_rout
);
    logic [3:0]  w_sel;
    logic [15:0] w_onehot;

    // Field mux and one-hot expansion of the chosen register number.
    always_comb begin
        w_sel = 4'd0;
        if (i_gra)      w_sel = i_ra;
        else if (i_grb) w_sel = i_rb;
        else if (i_grc) w_sel = i_rc;
        w_onehot = 16'd1 << w_sel;
    end

    assign o_rin  = i_rin_en  ? (w_onehot & 16'hFFFE) : 16'd0;
    assign o_rout = i_rout_en ? w_onehot : 16'd0;

endmodule

// File: rtl/mini_src_control_unit.sv
// Mini SRC hardwired control unit: state register, step counter and
// combinational strobe decode from the registered state.
// Optional feature macro: MINI_SRC_MULDIV_EN (mul/div/mfhi/mflo support).
//
// state   | meaning
// S_RESET | holding after reset for RESET_PC_HOLD cycles
// S_FETCH | T0..T3 instruction fetch
// S_EXEC  | T4..T9 execute sequence of the decoded instruction
// S_HALT  | stopped (halt, Stop request or illegal opcode) until reset
module mini_src_control_unit
    import mini_src_pkg::*;
#(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic                    Clock,
    input  logic                    Clear,
    mini_src_control_unit_if.master bus
);
    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic                r_illegal;
    logic                r_stop_pend;

    logic [4:0]          w_op;
    iclass_t             w_class;
    alu_t                w_alu;
    logic [STEP_W-1:0]   w_last;
    logic                w_gra, w_grb, w_grc, w_rin_en, w_rout_en, w_alu_en;
`ifdef MINI_SRC_MULDIV_EN
    logic                w_loin, w_hiin, w_loout, w_hiout;
`endif

    assign w_op    = bus.IR[IR_OP_MSB:IR_OP_LSB];
    assign w_class = classify(w_op);
    assign w_alu   = alu_of(w_op);
    assign w_last  = last_step(w_class);

    // Sequencer. A Stop request is remembered until the next instruction boundary.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state     <= S_RESET;
            r_step      <= '0;
            r_illegal   <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            if (bus.Stop) r_stop_pend <= 1'b1;
            case (r_state)
                S_RESET: begin
                    if (r_step == STEP_W'(RESET_PC_HOLD - 1)) begin
                        r_state <= S_FETCH;
                        r_step  <= T0;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_FETCH: begin
                    if (r_step == T3) r_state <= S_EXEC;
                    r_step <= r_step + 1'b1;
                end
                S_EXEC: begin
                    if (r_step == T4 && w_class == C_ILLEGAL) begin
                        r_illegal <= 1'b1;
                        r_state   <= S_HALT;
                    end else if (r_step == T4 && w_class == C_HALT) begin
                        r_state <= S_HALT;
                    end else if (r_step == w_last) begin
                        r_state <= (bus.Stop || r_stop_pend) ? S_HALT : S_FETCH;
                        r_step  <= T0;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Strobe decode: fetch steps are fixed, execute steps depend on the class.
    always_comb begin
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0; bus.MDRout = 1'b0;
        bus.Cout  = 1'b0; bus.PCin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
        bus.Zin   = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.IncPC = 1'b0;
        bus.Read  = 1'b0; bus.RAMRead = 1'b0; bus.RAMWrite = 1'b0;
        w_gra = 1'b0; w_grb = 1'b0; w_grc = 1'b0;
        w_rin_en = 1'b0; w_rout_en = 1'b0; w_alu_en = 1'b0;
`ifdef MINI_SRC_MULDIV_EN
        w_loin = 1'b0; w_hiin = 1'b0; w_loout = 1'b0; w_hiout = 1'b0;
`endif
        if (r_state == S_FETCH) begin
            case (r_step)
                4'd0:    begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
                4'd1:    begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.RAMRead = 1'b1; end
                4'd2:    begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                default: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            endcase
        end else if (r_state == S_EXEC) begin
            case (w_class)
                C_RALU, C_IMM: begin
                    case (r_step)
                        T4: begin w_grb = 1'b1; w_rout_en = 1'b1; bus.Yin = 1'b1; end
                        T5: begin
                            if (w_class == C_RALU) begin w_grc = 1'b1; w_rout_en = 1'b1; end
                            else bus.Cout = 1'b1;
                            w_alu_en = 1'b1; bus.Zin = 1'b1;
                        end
                        T6: begin bus.Zlowout = 1'b1; w_gra = 1'b1; w_rin_en = 1'b1; end
                        default: ;
                    endcase
                end
                C_UNARY: begin
                    case (r_step)
                        T4: begin w_grb = 1'b1; w_rout_en = 1'b1; w_alu_en = 1'b1; bus.Zin = 1'b1; end
                        T5: begin bus.Zlowout = 1'b1; w_gra = 1'b1; w_rin_en = 1'b1; end
                        default: ;
                    endcase
                end
                C_LD, C_ST: begin
                    case (r_step)
                        T4: begin w_grb = 1'b1; w_rout_en = 1'b1; bus.Yin = 1'b1; end
                        T5: begin bus.Cout = 1'b1; w_alu_en = 1'b1; bus.Zin = 1'b1; end
                        T6: begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                        T7: begin
                            if (w_class == C_LD) bus.RAMRead = 1'b1;
                            else begin w_gra = 1'b1; w_rout_en = 1'b1; bus.MDRin = 1'b1; end
                        end
                        T8: begin
                            if (w_class == C_LD) begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                            else begin bus.MDRout = 1'b1; bus.RAMWrite = 1'b1; end
                        end
                        T9: begin bus.MDRout = 1'b1; w_gra = 1'b1; w_rin_en = 1'b1; end
                        default: ;
                    endcase
                end
`ifdef MINI_SRC_MULDIV_EN
                C_MULDIV: begin
                    case (r_step)
                        T4: begin w_gra = 1'b1; w_rout_en = 1'b1; bus.Yin = 1'b1; end
                        T5: begin w_grb = 1'b1; w_rout_en = 1'b1; w_alu_en = 1'b1; bus.Zin = 1'b1; end
                        T6: begin bus.Zlowout = 1'b1; w_loin = 1'b1; end
                        T7: begin bus.Zhighout = 1'b1; w_hiin = 1'b1; end
                        default: ;
                    endcase
                end
                C_MFHI: begin w_hiout = 1'b1; w_gra = 1'b1; w_rin_en = 1'b1; end
                C_MFLO: begin w_loout = 1'b1; w_gra = 1'b1; w_rin_en = 1'b1; end
`endif
                default: ;
            endcase
        end
    end

    mini_src_reg_select u_reg_select (
        .i_ra      (bus.IR[IR_RA_MSB:IR_RA_LSB]),
        .i_rb      (bus.IR[IR_RB_MSB:IR_RB_LSB]),
        .i_rc      (bus.IR[IR_RC_MSB:IR_RC_LSB]),
        .i_gra     (w_gra),
        .i_grb     (w_grb),
        .i_grc     (w_grc),
        .i_rin_en  (w_rin_en),
        .i_rout_en (w_rout_en),
        .o_rin     (bus.Rin),
        .o_rout    (bus.Rout)
    );

    assign bus.Run     = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign bus.Illegal = r_illegal;

    assign bus.ADD  = w_alu_en && (w_alu == A_ADD);
    assign bus.SUB  = w_alu_en && (w_alu == A_SUB);
    assign bus.SHR  = w_alu_en && (w_alu == A_SHR);
    assign bus.SHRA = w_alu_en && (w_alu == A_SHRA);
    assign bus.SHL  = w_alu_en && (w_alu == A_SHL);
    assign bus.ROR  = w_alu_en && (w_alu == A_ROR);
    assign bus.ROL  = w_alu_en && (w_alu == A_ROL);
    assign bus.AND  = w_alu_en && (w_alu == A_AND);
    assign bus.OR   = w_alu_en && (w_alu == A_OR);
    assign bus.NEG  = w_alu_en && (w_alu == A_NEG);
    assign bus.NOT  = w_alu_en && (w_alu == A_NOT);

`ifdef MINI_SRC_MULDIV_EN
    assign bus.MUL   = w_alu_en && (w_alu == A_MUL);
    assign bus.DIV   = w_alu_en && (w_alu == A_DIV);
    assign bus.LOin  = w_loin;
    assign bus.HIin  = w_hiin;
    assign bus.LOout = w_loout;
    assign bus.HIout = w_hiout;
`else
    assign bus.MUL   = 1'b0;
    assign bus.DIV   = 1'b0;
    assign bus.LOin  = 1'b0;
    assign bus.HIin  = 1'b0;
    assign bus.LOout = 1'b0;
    assign bus.HIout = 1'b0;
`endif

endmodule
